// File: rtl/rv32i_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, ALU codes,
// FSM states and datapath select values.
package rv32i_pkg;

   localparam int unsigned OP_W    = 7;
   localparam int unsigned ALU_W   = 3;
   localparam int unsigned SEL_W   = 2;

   // ALU operation codes shared with the ALU
   typedef enum logic [ALU_W-1:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctrl_e;

   // Supported opcodes
   localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
   localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
   localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BRANCH,
      S_JAL,
      S_ILLEGAL
   } state_e;

   // result_src
   localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
   localparam logic [SEL_W-1:0] RES_RDATA  = 2'b01;
   localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;
   // alu_src_a
   localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
   localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
   localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;
   // alu_src_b
   localparam logic [SEL_W-1:0] SRCB_RS2   = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;
   // imm_src
   localparam logic [SEL_W-1:0] IMM_I      = 2'b00;
   localparam logic [SEL_W-1:0] IMM_S      = 2'b01;
   localparam logic [SEL_W-1:0] IMM_B      = 2'b10;
   localparam logic [SEL_W-1:0] IMM_J      = 2'b11;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: maps funct3/funct7b5 to an ALU operation and flags
// unsupported encodings.
//   funct3, funct7b5 : instruction fields
//   is_rtype         : 1 for register-register ops (funct7b5 selects SUB)
//   alu_ctrl         : ALU operation code
//   legal            : encoding is supported
module alu_decoder
   import rv32i_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       is_rtype,
   output logic [2:0] alu_ctrl,
   output logic       legal
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      legal    = 1'b1;
      case (funct3)
         3'b000:  if (is_rtype && funct7b5) alu_ctrl = ALU_SUB;
         3'b010:  alu_ctrl = ALU_SLT;
         3'b110:  alu_ctrl = ALU_OR;
         3'b111:  alu_ctrl = ALU_AND;
         default: legal = 1'b0;
      endcase
      // funct7b5 only has meaning for add/sub on register ops
      if (is_rtype && funct7b5 && (funct3 != 3'b000)) legal = 1'b0;
   end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for the multicycle RV32I datapath.
//   clk, rst        : clock, async active-high reset
//   op/funct3/funct7b5 : instruction register fields
//   zero, mem_ready : ALU zero flag, memory completion handshake
//   pc_write, ir_write, mem_write, reg_write : datapath enables
//   adr_src, result_src, alu_src_a, alu_src_b, imm_src : datapath selects
//   alu_ctrl        : ALU operation
//   illegal         : one-cycle pulse on unsupported instruction
module multicycle_controller
   import rv32i_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_ctrl,
   output logic [1:0] imm_src,
   output logic       illegal
);

   state_e     r_state;
   state_e     w_next;
   logic       w_is_rtype;
   logic [2:0] w_dec_ctrl;
   logic       w_dec_legal;
   logic       w_pc_write;
   logic       w_ir_write;
   logic       w_mem_write;
   logic       w_reg_write;
   logic       w_illegal;

   assign w_is_rtype = (op == OP_RTYPE);

   alu_decoder u_alu_decoder (
      .funct3   (funct3),
      .funct7b5 (funct7b5),
      .is_rtype (w_is_rtype),
      .alu_ctrl (w_dec_ctrl),
      .legal    (w_dec_legal)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_next;
   end

   // Next state and Moore outputs (mem_ready / zero gating where noted)
   always_comb begin
      w_next      = r_state;
      w_pc_write  = 1'b0;
      w_ir_write  = 1'b0;
      w_mem_write = 1'b0;
      w_reg_write = 1'b0;
      w_illegal   = 1'b0;
      adr_src     = 1'b0;
      result_src  = RES_ALUOUT;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_RS2;
      alu_ctrl    = ALU_ADD;
      imm_src     = IMM_I;

      case (r_state)
         S_FETCH: begin
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
            w_ir_write = mem_ready;
            w_pc_write = mem_ready;
            if (mem_ready) w_next = S_DECODE;
         end
         S_DECODE: begin
            // Branch/jump target goes into ALUOut while the op is decoded
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (op)
               OP_STORE:  imm_src = IMM_S;
               OP_BRANCH: imm_src = IMM_B;
               OP_JAL:    imm_src = IMM_J;
               default:   imm_src = IMM_I;
            endcase
            case (op)
               OP_LOAD, OP_STORE: w_next = S_MEMADR;
               OP_RTYPE:  w_next = w_dec_legal ? S_EXECR : S_ILLEGAL;
               OP_ITYPE:  w_next = w_dec_legal ? S_EXECI : S_ILLEGAL;
               OP_BRANCH: w_next = (funct3[2:1] == 2'b00) ? S_BRANCH : S_ILLEGAL;
               OP_JAL:    w_next = S_JAL;
               default:   w_next = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
            w_next    = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            if (mem_ready) w_next = S_MEMWB;
         end
         S_MEMWB: begin
            result_src  = RES_RDATA;
            w_reg_write = 1'b1;
            w_next      = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src     = 1'b1;
            w_mem_write = 1'b1;
            if (mem_ready) w_next = S_FETCH;
         end
         S_EXECR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_RS2;
            alu_ctrl  = w_dec_ctrl;
            w_next    = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_ctrl  = w_dec_ctrl;
            w_next    = S_ALUWB;
         end
         S_ALUWB: begin
            w_reg_write = 1'b1;
            w_next      = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_RS2;
            alu_ctrl   = ALU_SUB;
            // funct3[0] distinguishes bne from beq
            w_pc_write = funct3[0] ? ~zero : zero;
            w_next     = S_FETCH;
         end
         S_JAL: begin
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            w_pc_write = 1'b1;
            w_next     = S_ALUWB;
         end
         S_ILLEGAL: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase
   end

   // Enables are squashed immediately while reset is held
   assign pc_write  = w_pc_write  & ~rst;
   assign ir_write  = w_ir_write  & ~rst;
   assign mem_write = w_mem_write & ~rst;
   assign reg_write = w_reg_write & ~rst;
   assign illegal   = w_illegal   & ~rst;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multicycle RV32I datapath. It is the producer side of the ALU interface: it drives `alu_ctrl` and the datapath mux selects, and it consumes the ALU `zero` flag.
- Sequences each instruction through fetch, decode, execute, memory and writeback, one state per clock.
- Shares a single memory port and stalls on a `mem_ready` handshake.
- Supports `lw`, `sw`, R-type (`add`, `sub`, `and`, `or`, `slt`), I-type (`addi`, `andi`, `ori`, `slti`), `beq`, `bne` and `jal`.

Parameters:
- None. All encodings live in `rv32i_pkg`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `op` input 7: opcode from the instruction register.
- `funct3` input 3: `instr[14:12]` from the instruction register.
- `funct7b5` input 1: `instr[30]` from the instruction register.
- `zero` input 1: ALU `zero` flag, i.e. `alu_out == 0`.
- `mem_ready` input 1: memory has completed the current read or write this cycle.
- `pc_write` output 1: load the PC from `result`.
- `ir_write` output 1: load the instruction register and the old-PC register.
- `adr_src` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_write` output 1: memory write request.
- `reg_write` output 1: register file write enable.
- `result_src` output 2: result select; 00 = ALUOut, 01 = read data, 10 = alu_out.
- `alu_src_a` output 2: ALU operand A select; 00 = PC, 01 = old PC, 10 = rs1.
- `alu_src_b` output 2: ALU operand B select; 00 = rs2, 01 = immediate, 10 = constant 4.
- `alu_ctrl` output 3: ALU operation; ADD 000, SUB 001, AND 010, OR 011, SLT 101.
- `imm_src` output 2: immediate format; 00 = I, 01 = S, 10 = B, 11 = J.
- `illegal` output 1: one-cycle pulse when an unsupported instruction is decoded.

Behaviour:
- Reset:
  - `rst` asynchronously forces the state to FETCH.
  - While `rst` is high, `pc_write`, `ir_write`, `mem_write`, `reg_write` and `illegal` are 0.
  - All other outputs take their FETCH values.
  - Reset in mid-instruction abandons the instruction; no partial writes are issued after `rst` asserts.
- Output timing:
  - Outputs are Moore, decoded from the state. The only exceptions are the `mem_ready` and `zero` gating noted below.
  - Any select not listed for a state is 00, and `alu_ctrl` defaults to ADD.
- FETCH:
  - Outputs: `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, ADD, `result_src`=10.
  - `ir_write` and `pc_write` are each equal to `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; moves to DECODE on `mem_ready`=1.
- DECODE:
  - Outputs: `alu_src_a`=01, `alu_src_b`=01, ADD. This computes the branch/jump target into ALUOut.
  - `imm_src` is chosen by `op`: I for load and I-ALU, S for store, B for branch, J for jal.
  - Next state:
    - `lw` or `sw` -> MEMADR
    - R-type -> EXECR
    - I-ALU -> EXECI
    - `beq`/`bne` -> BRANCH
    - `jal` -> JAL
    - anything else -> ILLEGAL
  - Legality is also checked here:
    - R-type and I-ALU must have `funct3` in {000, 010, 110, 111}.
    - R-type with `funct7b5`=1 is legal only with `funct3`=000.
    - Branches must have `funct3` in {000, 001}.
    - Anything else -> ILLEGAL.
- MEMADR:
  - Outputs: `alu_src_a`=10, `alu_src_b`=01, `imm_src` I for `lw` or S for `sw`, ADD.
  - Next state: MEMREAD for `lw`, MEMWRITE for `sw`.
- MEMREAD:
  - Outputs: `adr_src`=1, `result_src`=00.
  - Waits in MEMREAD until `mem_ready`=1, then goes to MEMWB.
- MEMWB:
  - Outputs: `result_src`=01, `reg_write`=1.
  - Next state: FETCH.
- MEMWRITE:
  - Outputs: `adr_src`=1, `result_src`=00, `mem_write`=1 held every cycle until `mem_ready`=1.
  - Next state: FETCH.
- EXECR:
  - Outputs: `alu_src_a`=10, `alu_src_b`=00.
  - `alu_ctrl` mapping:
    - `funct3`=000 -> SUB if `funct7b5`=1, otherwise ADD
    - 010 -> SLT
    - 110 -> OR
    - 111 -> AND
  - Next state: ALUWB.
- EXECI:
  - Outputs: `alu_src_a`=10, `alu_src_b`=01, `imm_src` I.
  - Same `alu_ctrl` mapping as EXECR, except `funct7b5` is ignored, so `funct3`=000 always gives ADD.
  - Next state: ALUWB.
- ALUWB:
  - Outputs: `result_src`=00, `reg_write`=1.
  - Next state: FETCH.
- BRANCH:
  - Outputs: `alu_src_a`=10, `alu_src_b`=00, SUB, `result_src`=00.
  - `pc_write` is `zero` for `beq` and `!zero` for `bne`.
  - Next state: FETCH.
- JAL:
  - Outputs: `alu_src_a`=01, `alu_src_b`=10, ADD, `result_src`=00, `pc_write`=1.
  - Next state: ALUWB, which writes PC+4 to rd.
- ILLEGAL:
  - Outputs: `illegal`=1 for exactly one cycle; no enables asserted.
  - Next state: FETCH.
- Instruction latency with zero-wait memory:
  - `lw` = 5 cycles
  - `sw`, R-type, I-ALU and `jal` = 4 cycles
  - `beq`/`bne` = 3 cycles
  - Each memory wait cycle adds 1.
- Invariants:
  - At most one of `mem_write`, `reg_write` and `ir_write` is high in any cycle.
  - `pc_write` and `ir_write` coincide only in FETCH.

Decomposition:
- `rv32i_pkg` holds:
  - the `alu_ctrl_e` codes; the ALU switches to these codes from its local constants
  - opcode constants
  - the `state_e` enum
  - select encodings for `result_src`, `alu_src_a`, `alu_src_b` and `imm_src`
- One sub-module, `alu_decoder`: combinational. Inputs are `funct3`, `funct7b5` and `is_rtype`; outputs are `alu_ctrl` and a `legal` flag.

Test Plan:
- `add` (op 0110011, `funct3` 000, `funct7b5` 0), `mem_ready`=1 -> states FETCH, DECODE, EXECR, ALUWB, then FETCH. `alu_ctrl`=000 in EXECR; `reg_write`=1 only in ALUWB.
- `sub` with `funct7b5`=1 -> `alu_ctrl`=001 in EXECR. `slt` -> 101. `andi` -> 010 with `alu_src_b`=01.
- `lw` with `mem_ready` low for 3 cycles in MEMREAD -> 8 cycles total. `adr_src`=1 throughout MEMREAD; `reg_write` pulses once, with `result_src`=01.
- `beq` with `zero`=1 -> `pc_write`=1 in BRANCH. `bne` with `zero`=1 -> `pc_write`=0. Both return to FETCH after 3 cycles.
- Opcode 1110011 -> `illegal` pulses exactly once; no writes occur; FETCH follows.
- `rst` asserted mid-way through MEMWRITE with `mem_ready`=0 -> `mem_write` drops in the same cycle, without waiting for a clock edge. State is FETCH when `rst` is released.
